// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Requester and memory-side signal bundle for mem_port_arbiter
// slave is the arbiter's view; master is the view of the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_ack;

    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Round-robin arbiter sharing one memory port between controller and loader
// Each grant runs IDLE -> ACCESS (MEM_LAT strobe cycles) -> ACK; every output is a flop.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic          busy_q, busy_d;

    logic          grant_ldr;
    logic          sel_we;

    // On a tie the requester that did not win last time is served.
    assign grant_ldr = bus.ldr_req & (~bus.cpu_req | ~last_owner_q);
    assign sel_we    = grant_ldr ? bus.ldr_we : bus.cpu_we;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        cpu_ack_d    = 1'b0;
        ldr_ack_d    = 1'b0;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req | bus.ldr_req) begin
                    owner_d      = grant_ldr;
                    last_owner_d = grant_ldr;
                    we_d         = sel_we;
                    addr_d       = grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    wdata_d      = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                    cnt_d        = LAT_LOAD;
                    mem_rd_d     = ~sel_we;
                    mem_wr_d     = sel_we;
                    busy_d       = 1'b1;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!we_q) begin
                        if (owner_q) ldr_rdata_d = bus.mem_rdata;
                        else         cpu_rdata_d = bus.mem_rdata;
                    end
                    cpu_ack_d = ~owner_q;
                    ldr_ack_d = owner_q;
                    state_d   = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.ldr_ack   = ldr_ack_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the datapath's single memory port between the instruction controller and a program loader/debug port. Each requester holds a registered request until it receives a one-cycle acknowledge. The block drives the memory read and write strobes for a fixed, parameterised access latency. Arbitration is round-robin, so a continuously requesting loader cannot starve instruction fetch, and the controller cannot starve the loader.

## Interface
- AW, 8, address width
- DW, 16, data width (instruction/word width)
- MEM_LAT, 2, cycles each strobe is held; legal range 1..15
- clk  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- cpu_req  in  1  controller request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  controller address
- cpu_wdata  in  DW  controller write data
- cpu_rdata  out  DW  read data, valid in cpu_ack cycle, held afterwards
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req / ldr_we / ldr_addr / ldr_wdata / ldr_rdata / ldr_ack  same widths and meaning, loader side
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AW  latched address of granted transaction
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in every non-IDLE state
- owner  out  1  0 = controller, 1 = loader; current or last grant

## Operation
- States:
  - IDLE: arbitrate. No request → stay IDLE. Otherwise grant, latch the winner's we/addr/wdata, load the latency counter with MEM_LAT-1, go to ACCESS.
  - ACCESS: mem_rd = ~we_q, mem_wr = we_q. On counter = 0, capture mem_rdata into the winner's rdata register (reads only) and go to ACK. Otherwise decrement.
  - ACK: pulse the winner's ack, then go to IDLE unconditionally.
- Arbitration:
  - If exactly one request is asserted, that requester wins.
  - If both are asserted, the requester not equal to last_owner wins.
  - last_owner updates at each grant. Its reset value is loader, so the controller wins the first tie.
- Request and ack protocol:
  - Address and data are sampled only at grant; later changes on inputs are ignored.
  - A requester deasserts req on the edge ending its ack cycle. A req seen in IDLE is always a new transaction.
  - If req drops during ACCESS, the access still completes and ack still pulses. No abort.
- Write data never reaches rdata; rdata changes only on read completion.
- Reset (any state): on the next edge go to IDLE and clear all outputs, rdata registers, latches and counter. owner = 0, last_owner = loader.
- Reset mid-access: the transaction is dropped silently and no ack is issued.

## Timing
- Grant:
  - A request seen at the edge ending IDLE cycle t starts ACCESS at t+1.
  - Strobes are high in cycles t+1..t+MEM_LAT.
  - ack is high in cycle t+MEM_LAT+1, with rdata valid in the same cycle.
  - The block is back in IDLE at cycle t+MEM_LAT+2.
- Throughput: one transaction per MEM_LAT+2 cycles. With both requesting continuously, grants alternate cpu, ldr, cpu, …
- mem_rdata is sampled at the edge ending the last strobe cycle.
- mem_addr and mem_wdata are stable for the whole ACCESS phase. Their value in other states is don't-care; they hold the last latched value.
- mem_rd and mem_wr are never both high. Both are low in IDLE and ACK.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Single read: MEM_LAT=2, cpu_req at cycle 1, addr 0x05, mem returns 0x1234. Required: mem_rd high cycles 2–3; cpu_ack and cpu_rdata=0x1234 at cycle 4; busy low from cycle 5; ldr_ack never asserted.
- Loader write: ldr_req, we=1, addr 0x10, wdata 0xBEEF. Required: mem_wr high for 2 cycles with mem_addr=0x10 and mem_wdata=0xBEEF; ldr_ack pulses once; ldr_rdata unchanged.
- Contention: both requesters hold req for 4 transactions. Required: owner sequence 0,1,0,1 with each ack spaced 4 cycles apart.
- Input change after grant: cpu_addr switches 0x05→0x06 during ACCESS. Required: mem_addr stays 0x05.
- Reset mid-access: reset low during the first ACCESS cycle. Required: next cycle shows IDLE, strobes low, no ack, rdata=0, owner=0. A following cpu/ldr tie grants the controller.
- MEM_LAT=1 boundary: single read. Required: mem_rd high for exactly one cycle and ack two cycles after the request is sampled.
